// File: rtl/imem_uart_loader_pkg.sv
// Definitions shared by the UART program loader and its byte receiver.
package imem_uart_loader_pkg;

    localparam logic [7:0]  LOADER_SYNC_BYTE = 8'h5A;
    localparam int unsigned ISA_WIDTH        = 32;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StLen0,
        StLen1,
        StData,
        StChk,
        StDone,
        StError
    } loader_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

endpackage

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchronizer, half-bit start check, centre sampling.
module uart_rx_byte
    import imem_uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullBit = CntW'(CLKS_PER_BIT - 1);

    rx_state_e       state;
    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    logic [CntW-1:0] clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RxIdle;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= uart_rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RxIdle: begin
                    // Falling edge only, so a line stuck low after a bad stop bit is not re-read.
                    if (rx_prev && !rx_sync) begin
                        state   <= RxStart;
                        clk_cnt <= '0;
                    end
                end
                RxStart: begin
                    if (clk_cnt == HalfBit) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RxIdle : RxData;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (clk_cnt == FullBit) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= RxStop;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RxStop: begin
                    if (clk_cnt == FullBit) begin
                        clk_cnt <= '0;
                        state   <= RxIdle;
                        if (rx_sync) begin
                            byte_data  <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a program image from UART into the instruction memory, holding the CPU in reset meanwhile.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned TIMEOUT_CYC  = 5000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    input  logic                 start_load,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [ISA_WIDTH-1:0] imem_wdata,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_error,
    output logic [ADDR_W:0]      words_loaded
);

    localparam int unsigned ToW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYC);
    localparam int unsigned Capacity = 32'd1 << ADDR_W;

    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          frame_err;

    loader_state_e state;
    logic [1:0]    byte_cnt;
    logic [7:0]    len_lo;
    logic [15:0]   len_q;
    logic [23:0]   wdata_asm;
    logic [7:0]    chk;
    logic [ToW-1:0] to_cnt;

    logic [15:0]   len_next;
    logic          bad_len;
    logic          last_word;
    logic          in_frame;
    logic          active;
    logic          timed_out;
    logic          go_error;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign len_next  = {byte_data, len_lo};
    assign bad_len   = (len_next == 16'd0) || (32'(len_next) > Capacity);
    assign last_word = (32'(words_loaded) + 32'd1) == 32'(len_q);
    assign in_frame  = (state == StLen0) || (state == StLen1) || (state == StData)
                    || (state == StChk);
    assign active    = in_frame || (state == StSync);
    assign timed_out = in_frame && !byte_valid && (to_cnt == ToMax);
    assign go_error  = (active && frame_err) || timed_out
                    || ((state == StLen1) && byte_valid && bad_len)
                    || ((state == StChk) && byte_valid && (byte_data != chk));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            byte_cnt     <= '0;
            len_lo       <= '0;
            len_q        <= '0;
            wdata_asm    <= '0;
            chk          <= '0;
            to_cnt       <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            if (byte_valid || !in_frame) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (start_load) begin
                // Arming from any state aborts whatever frame was in flight.
                state        <= StSync;
                byte_cnt     <= '0;
                chk          <= '0;
                to_cnt       <= '0;
                cpu_hold     <= 1'b1;
                load_done    <= 1'b0;
                load_error   <= 1'b0;
                words_loaded <= '0;
            end else if (go_error) begin
                state      <= StError;
                load_error <= 1'b1;
            end else if (byte_valid) begin
                case (state)
                    StSync: begin
                        if (byte_data == LOADER_SYNC_BYTE) begin
                            state <= StLen0;
                        end
                    end
                    StLen0: begin
                        len_lo <= byte_data;
                        state  <= StLen1;
                    end
                    StLen1: begin
                        len_q <= len_next;
                        state <= StData;
                    end
                    StData: begin
                        chk      <= chk ^ byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= words_loaded[ADDR_W-1:0];
                            imem_wdata   <= {byte_data, wdata_asm};
                            words_loaded <= words_loaded + 1'b1;
                            if (last_word) begin
                                state <= StChk;
                            end
                        end else begin
                            wdata_asm <= {byte_data, wdata_asm[23:8]};
                        end
                    end
                    StChk: begin
                        state     <= StDone;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
